// File: rtl/draw_cmdfetch_if.sv
`default_nettype none
// ============================================================================
// Module      : draw_cmdfetch_if
// Description : Bus bundle between the draw command fetcher, the command FIFO
//               (show-ahead read side) and the draw engine.
//               master = fetcher side, slave = FIFO/engine side.
// Signals     : CMD_RDATA  [31:0] FIFO head word, valid while CMD_EMPTY=0
//               CMD_EMPTY         FIFO empty
//               CMD_RD_EN         pop request (consumes head word this cycle)
//               OP_VALID          decoded operation valid
//               OP_READY          engine accepts operation
//               OP_CODE    [7:0]  opcode
//               OP_ARG     [23:0] header argument
//               OP_P0/OP_P1[31:0] parameter words (0 when unused)
//               ENG_BUSY          engine still rendering
// Revision    : 1.0 - initial release
// ============================================================================
interface draw_cmdfetch_if;
  logic [31:0] CMD_RDATA;
  logic        CMD_EMPTY;
  logic        CMD_RD_EN;
  logic        OP_VALID;
  logic        OP_READY;
  logic [7:0]  OP_CODE;
  logic [23:0] OP_ARG;
  logic [31:0] OP_P0;
  logic [31:0] OP_P1;
  logic        ENG_BUSY;

  modport master (
    input  CMD_RDATA, CMD_EMPTY, OP_READY, ENG_BUSY,
    output CMD_RD_EN, OP_VALID, OP_CODE, OP_ARG, OP_P0, OP_P1
  );

  modport slave (
    output CMD_RDATA, CMD_EMPTY, OP_READY, ENG_BUSY,
    input  CMD_RD_EN, OP_VALID, OP_CODE, OP_ARG, OP_P0, OP_P1
  );
endinterface
`default_nettype wire

// File: rtl/draw_cmdfetch.sv
`default_nettype none
// ============================================================================
// Module      : draw_cmdfetch
// Description : Fetches a draw command list from a show-ahead FIFO, decodes
//               header + parameter words and hands each operation to the
//               draw engine with a valid/ready handshake. An EOD opcode waits
//               for the engine to go idle and then pulses DRAW_DONE.
// Ports       : CLK        system clock (rising edge)
//               ARST       asynchronous active-high reset
//               REG_EXE    execute enable level (sampled only when idle)
//               REG_RST    synchronous soft reset
//               bus        draw_cmdfetch_if.master (FIFO + engine signals)
//               DRAW_BUSY  list execution in progress
//               DRAW_DONE  one-cycle pulse at end of list
//               CMD_ERR    sticky unknown-opcode flag
// Revision    : 1.0 - initial release
// ============================================================================
module draw_cmdfetch (
  input  logic            CLK,
  input  logic            ARST,
  input  logic            REG_EXE,
  input  logic            REG_RST,
  draw_cmdfetch_if.master bus,
  output logic            DRAW_BUSY,
  output logic            DRAW_DONE,
  output logic            CMD_ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_PARAM = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] OPC_NOP      = 8'h00;
  localparam logic [7:0] OPC_SETFRAME = 8'h01;
  localparam logic [7:0] OPC_SETCOLOR = 8'h02;
  localparam logic [7:0] OPC_RECT     = 8'h03;
  localparam logic [7:0] OPC_EOD      = 8'h0F;

  function automatic logic [1:0] param_count(input logic [7:0] opc);
    case (opc)
      OPC_SETFRAME, OPC_RECT: param_count = 2'd2;
      OPC_SETCOLOR:           param_count = 2'd1;
      default:                param_count = 2'd0;
    endcase
  endfunction

  function automatic logic opc_known(input logic [7:0] opc);
    case (opc)
      OPC_NOP, OPC_SETFRAME, OPC_SETCOLOR, OPC_RECT, OPC_EOD: opc_known = 1'b1;
      default:                                                opc_known = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        idx_q, idx_d;        // index of the next parameter word
  logic [7:0]  code_q, code_d;
  logic [23:0] arg_q, arg_d;
  logic [31:0] p0_q, p0_d;
  logic [31:0] p1_q, p1_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [7:0]  hdr_opc;
  assign hdr_opc = bus.CMD_RDATA[31:24];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    arg_d   = arg_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (REG_EXE) begin
          state_d = S_HDR;
          err_d   = 1'b0;
        end
      end

      S_HDR: begin
        if (!bus.CMD_EMPTY) begin
          code_d = hdr_opc;
          arg_d  = bus.CMD_RDATA[23:0];
          // Unused parameter slots must read as zero for the new operation.
          p0_d   = '0;
          p1_d   = '0;
          idx_d  = 1'b0;
          if (!opc_known(hdr_opc)) begin
            err_d = 1'b1;
          end else if (hdr_opc == OPC_EOD) begin
            state_d = S_DRAIN;
          end else if (param_count(hdr_opc) != 2'd0) begin
            state_d = S_PARAM;
          end
        end
      end

      S_PARAM: begin
        if (!bus.CMD_EMPTY) begin
          if (idx_q) begin
            p1_d = bus.CMD_RDATA;
          end else begin
            p0_d = bus.CMD_RDATA;
          end
          if (({1'b0, idx_q} + 2'd1) == param_count(code_q)) begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
            idx_d   = 1'b0;
          end else begin
            idx_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (bus.OP_READY) begin
          valid_d = 1'b0;
          state_d = S_HDR;
        end
      end

      S_DRAIN: begin
        if (!bus.ENG_BUSY) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Soft reset abandons everything, including a pending handshake.
    if (REG_RST) begin
      state_d = S_IDLE;
      idx_d   = 1'b0;
      code_d  = '0;
      arg_d   = '0;
      p0_d    = '0;
      p1_d    = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // Busy is registered alongside the state so it is low in the DONE cycle.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= S_IDLE;
      idx_q   <= 1'b0;
      code_q  <= '0;
      arg_q   <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      arg_q   <= arg_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Pops are only possible in HDR/PARAM, so none can happen while OP_VALID=1.
  assign bus.CMD_RD_EN = ((state_q == S_HDR) || (state_q == S_PARAM)) && !bus.CMD_EMPTY;

  assign bus.OP_VALID = valid_q;
  assign bus.OP_CODE  = code_q;
  assign bus.OP_ARG   = arg_q;
  assign bus.OP_P0    = p0_q;
  assign bus.OP_P1    = p1_q;
  assign DRAW_BUSY    = busy_q;
  assign DRAW_DONE    = done_q;
  assign CMD_ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_cmdfetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_cmdfetch
// Description : Directed self-checking bench for draw_cmdfetch. A small
//               show-ahead FIFO model feeds the command words; a monitor
//               counts pops, valid cycles, handshakes and DONE pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_cmdfetch;

  logic CLK = 1'b0;
  logic ARST;
  logic REG_EXE;
  logic REG_RST;
  logic DRAW_BUSY;
  logic DRAW_DONE;
  logic CMD_ERR;

  draw_cmdfetch_if bus();

  draw_cmdfetch dut (
    .CLK       (CLK),
    .ARST      (ARST),
    .REG_EXE   (REG_EXE),
    .REG_RST   (REG_RST),
    .bus       (bus),
    .DRAW_BUSY (DRAW_BUSY),
    .DRAW_DONE (DRAW_DONE),
    .CMD_ERR   (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // FIFO model: main thread owns wr_ptr, monitor owns rd_ptr.
  logic [31:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign bus.CMD_EMPTY = (rd_ptr == wr_ptr);
  assign bus.CMD_RDATA = mem[rd_ptr[3:0]];

  int          hs_cnt    = 0;
  int          done_cnt  = 0;
  int          valid_cnt = 0;
  int          pop_cnt   = 0;
  logic [7:0]  hs_code   = '0;
  logic [23:0] hs_arg    = '0;
  logic [31:0] hs_p0     = '0;
  logic [31:0] hs_p1     = '0;
  logic        pop_now   = 1'b0;

  // Inputs change at negedge+1; the monitor samples at negedge+3 and the
  // FIFO model consumes a popped word at posedge+1.
  always begin
    @(negedge CLK);
    #3;
    pop_now = bus.CMD_RD_EN;
    if (bus.OP_VALID) valid_cnt++;
    if (bus.OP_VALID && bus.OP_READY) begin
      hs_cnt++;
      hs_code = bus.OP_CODE;
      hs_arg  = bus.OP_ARG;
      hs_p0   = bus.OP_P0;
      hs_p1   = bus.OP_P1;
    end
    if (DRAW_DONE) done_cnt++;
    @(posedge CLK);
    #1;
    if (pop_now) begin
      pop_cnt++;
      if (rd_ptr != wr_ptr) rd_ptr++;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr++;
  endtask

  task automatic test_reset();
    ARST = 1'b1; REG_EXE = 1'b0; REG_RST = 1'b0;
    bus.OP_READY = 1'b0; bus.ENG_BUSY = 1'b0;
    tick(); tick();
    total++; if (bus.OP_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.OP_VALID); end
    total++; if ({bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1} !== 96'h0) begin bad++;
      $display("FAIL reset_payload: got %h %h %h %h want zeros", bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1); end
    total++; if ({DRAW_BUSY, DRAW_DONE, CMD_ERR, bus.CMD_RD_EN} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags: got busy/done/err/rden=%b want 0000", {DRAW_BUSY, DRAW_DONE, CMD_ERR, bus.CMD_RD_EN}); end
    ARST = 1'b0;
    tick();
  endtask

  task automatic test_rect();
    int hs0, pop0, d0;
    hs0 = hs_cnt; pop0 = pop_cnt; d0 = done_cnt;
    push(32'h03000005); push(32'h00100020); push(32'h00400030); push(32'h0F000000);
    bus.OP_READY = 1'b1;
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    total++; if (DRAW_BUSY !== 1'b1) begin bad++; $display("FAIL rect_busy_hdr: got %b want 1", DRAW_BUSY); end
    tick(); tick();
    total++; if (bus.OP_VALID !== 1'b0) begin bad++; $display("FAIL rect_valid_early: got %b want 0", bus.OP_VALID); end
    tick();
    total++; if (bus.OP_VALID !== 1'b1) begin bad++; $display("FAIL rect_valid_latency: got %b want 1", bus.OP_VALID); end
    tick();
    total++; if (bus.OP_VALID !== 1'b0) begin bad++; $display("FAIL rect_valid_drop: got %b want 0", bus.OP_VALID); end
    total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL rect_hs_count: got %0d want 1", hs_cnt - hs0); end
    total++; if ({hs_code, hs_arg, hs_p0, hs_p1} !== {8'h03, 24'h000005, 32'h00100020, 32'h00400030}) begin bad++;
      $display("FAIL rect_payload: got %h %h %h %h want 03 000005 00100020 00400030", hs_code, hs_arg, hs_p0, hs_p1); end
    tick();
    total++; if ({DRAW_DONE, DRAW_BUSY} !== 2'b01) begin bad++; $display("FAIL rect_drain: got done/busy=%b want 01", {DRAW_DONE, DRAW_BUSY}); end
    tick();
    total++; if ({DRAW_DONE, DRAW_BUSY} !== 2'b10) begin bad++; $display("FAIL rect_done: got done/busy=%b want 10", {DRAW_DONE, DRAW_BUSY}); end
    tick();
    total++; if ({DRAW_DONE, DRAW_BUSY} !== 2'b00) begin bad++; $display("FAIL rect_idle: got done/busy=%b want 00", {DRAW_DONE, DRAW_BUSY}); end
    total++; if (pop_cnt - pop0 !== 4 || done_cnt - d0 !== 1) begin bad++;
      $display("FAIL rect_counts: got pops=%0d dones=%0d want 4 1", pop_cnt - pop0, done_cnt - d0); end
  endtask

  task automatic test_stall();
    int hs0, n;
    hs0 = hs_cnt;
    push(32'h03000005); push(32'h00100020); push(32'h00400030); push(32'h0F000000);
    bus.OP_READY = 1'b0;
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.OP_VALID, bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1, bus.CMD_RD_EN} !==
          {1'b1, 8'h03, 24'h000005, 32'h00100020, 32'h00400030, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got v=%b %h %h %h %h rden=%b want v=1 03 000005 00100020 00400030 rden=0",
                 i, bus.OP_VALID, bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1, bus.CMD_RD_EN);
      end
      tick();
    end
    total++; if (hs_cnt - hs0 !== 0) begin bad++; $display("FAIL stall_no_hs: got %0d want 0", hs_cnt - hs0); end
    bus.OP_READY = 1'b1;
    total++; if (bus.OP_VALID !== 1'b1) begin bad++; $display("FAIL stall_valid_11: got %b want 1", bus.OP_VALID); end
    tick();
    total++; if (bus.OP_VALID !== 1'b0 || hs_cnt - hs0 !== 1) begin bad++;
      $display("FAIL stall_handshake: got valid=%b hs=%0d want 0 1", bus.OP_VALID, hs_cnt - hs0); end
    n = 0;
    while (DRAW_DONE !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (DRAW_DONE !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1 (timeout)", DRAW_DONE); end
    tick();
  endtask

  task automatic test_empty_wait();
    int pop0, n;
    pop0 = pop_cnt;
    bus.OP_READY = 1'b1;
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({DRAW_BUSY, bus.CMD_RD_EN} !== 2'b10) begin bad++;
        $display("FAIL empty_wait[%0d]: got busy/rden=%b want 10", i, {DRAW_BUSY, bus.CMD_RD_EN}); end
      tick();
    end
    total++; if (pop_cnt - pop0 !== 0) begin bad++; $display("FAIL empty_pops: got %0d want 0", pop_cnt - pop0); end
    push(32'h02000000); push(32'h00FF00FF);
    n = 0;
    while (bus.OP_VALID !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if ({bus.OP_VALID, bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1} !== {1'b1, 8'h02, 24'h0, 32'h00FF00FF, 32'h0}) begin bad++;
      $display("FAIL empty_setcolor: got v=%b %h %h %h %h want v=1 02 000000 00ff00ff 00000000",
               bus.OP_VALID, bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1); end
    push(32'h0F000000);
    n = 0;
    while (DRAW_DONE !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (DRAW_DONE !== 1'b1) begin bad++; $display("FAIL empty_done: got %b want 1 (timeout)", DRAW_DONE); end
    tick();
  endtask

  task automatic test_bad_opcode();
    int hs0, v0, n;
    hs0 = hs_cnt; v0 = valid_cnt;
    push(32'h7A000000); push(32'h0F000000);
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    tick();
    total++; if (CMD_ERR !== 1'b1) begin bad++; $display("FAIL bad_err_set: got %b want 1", CMD_ERR); end
    n = 0;
    while (DRAW_DONE !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (DRAW_DONE !== 1'b1) begin bad++; $display("FAIL bad_done: got %b want 1 (timeout)", DRAW_DONE); end
    total++; if (CMD_ERR !== 1'b1 || valid_cnt - v0 !== 0 || hs_cnt - hs0 !== 0) begin bad++;
      $display("FAIL bad_no_issue: got err=%b valid_cycles=%0d hs=%0d want 1 0 0", CMD_ERR, valid_cnt - v0, hs_cnt - hs0); end
    tick();
    push(32'h0F000000);
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    total++; if ({CMD_ERR, DRAW_BUSY} !== 2'b01) begin bad++; $display("FAIL bad_err_clear: got err/busy=%b want 01", {CMD_ERR, DRAW_BUSY}); end
    n = 0;
    while (DRAW_DONE !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (DRAW_DONE !== 1'b1) begin bad++; $display("FAIL bad_done2: got %b want 1 (timeout)", DRAW_DONE); end
    tick();
  endtask

  task automatic test_drain();
    bus.ENG_BUSY = 1'b1;
    push(32'h0F000000);
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({DRAW_DONE, DRAW_BUSY} !== 2'b01) begin bad++;
        $display("FAIL drain_wait[%0d]: got done/busy=%b want 01", i, {DRAW_DONE, DRAW_BUSY}); end
      tick();
    end
    bus.ENG_BUSY = 1'b0;
    total++; if (DRAW_DONE !== 1'b0) begin bad++; $display("FAIL drain_early: got %b want 0", DRAW_DONE); end
    tick();
    total++; if ({DRAW_DONE, DRAW_BUSY} !== 2'b10) begin bad++; $display("FAIL drain_done: got done/busy=%b want 10", {DRAW_DONE, DRAW_BUSY}); end
    tick();
    total++; if (DRAW_DONE !== 1'b0) begin bad++; $display("FAIL drain_pulse: got %b want 0", DRAW_DONE); end
  endtask

  task automatic test_back_to_back();
    int hs0, d0, n;
    hs0 = hs_cnt; d0 = done_cnt;
    push(32'h02000000); push(32'h000000AA); push(32'h0F000000); push(32'h0F000000);
    bus.OP_READY = 1'b1;
    REG_EXE = 1'b1;
    n = 0;
    while (DRAW_DONE !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if ({DRAW_DONE, DRAW_BUSY} !== 2'b10) begin bad++; $display("FAIL b2b_first_done: got done/busy=%b want 10", {DRAW_DONE, DRAW_BUSY}); end
    tick();
    total++; if (DRAW_BUSY !== 1'b1) begin bad++; $display("FAIL b2b_restart: got %b want 1", DRAW_BUSY); end
    REG_EXE = 1'b0;
    n = 0;
    while (DRAW_DONE !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    total++; if (done_cnt - d0 !== 2 || hs_cnt - hs0 !== 1) begin bad++;
      $display("FAIL b2b_counts: got dones=%0d hs=%0d want 2 1", done_cnt - d0, hs_cnt - hs0); end
    total++; if ({hs_code, hs_p0, hs_p1} !== {8'h02, 32'h000000AA, 32'h0}) begin bad++;
      $display("FAIL b2b_payload: got %h %h %h want 02 000000aa 00000000", hs_code, hs_p0, hs_p1); end
  endtask

  task automatic test_soft_reset();
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    push(32'h01000007); push(32'h11111111); push(32'h22222222); push(32'h0F000000);
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    tick(); tick();
    total++; if (bus.OP_P0 !== 32'h11111111) begin bad++; $display("FAIL srst_mid_param: got %h want 11111111", bus.OP_P0); end
    REG_RST = 1'b1;
    tick();
    REG_RST = 1'b0;
    total++;
    if ({bus.OP_VALID, bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1, DRAW_BUSY, DRAW_DONE, CMD_ERR, bus.CMD_RD_EN} !== 101'h0) begin bad++;
      $display("FAIL srst_outputs: got v=%b %h %h %h %h busy=%b done=%b err=%b rden=%b want all 0",
               bus.OP_VALID, bus.OP_CODE, bus.OP_ARG, bus.OP_P0, bus.OP_P1, DRAW_BUSY, DRAW_DONE, CMD_ERR, bus.CMD_RD_EN); end
    wr_ptr = rd_ptr;
    for (int i = 0; i < 5; i++) tick();
    total++; if (valid_cnt - v0 !== 0 || done_cnt - d0 !== 0 || DRAW_BUSY !== 1'b0) begin bad++;
      $display("FAIL srst_quiet: got valid_cycles=%0d dones=%0d busy=%b want 0 0 0", valid_cnt - v0, done_cnt - d0, DRAW_BUSY); end
  endtask

  task automatic test_arst_issue();
    int hs0, n;
    push(32'h03000005); push(32'h00100020); push(32'h00400030); push(32'h0F000000);
    bus.OP_READY = 1'b0;
    REG_EXE = 1'b1;
    tick();
    REG_EXE = 1'b0;
    n = 0;
    while (bus.OP_VALID !== 1'b1 && n < 10) begin tick(); n++; end
    total++; if (bus.OP_VALID !== 1'b1) begin bad++; $display("FAIL arst_reach_issue: got %b want 1 (timeout)", bus.OP_VALID); end
    hs0 = hs_cnt;
    ARST = 1'b1;
    bus.OP_READY = 1'b1;
    #1;
    total++; if ({bus.OP_VALID, DRAW_BUSY} !== 2'b00) begin bad++; $display("FAIL arst_async: got valid/busy=%b want 00", {bus.OP_VALID, DRAW_BUSY}); end
    tick();
    total++; if (hs_cnt - hs0 !== 0) begin bad++; $display("FAIL arst_no_hs: got %0d want 0", hs_cnt - hs0); end
    ARST = 1'b0;
    wr_ptr = rd_ptr;
    tick();
  endtask

  initial begin
    test_reset();
    test_rect();
    test_stall();
    test_empty_wait();
    test_bad_opcode();
    test_drain();
    test_back_to_back();
    test_soft_reset();
    test_arst_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
